// File: rtl/ctech_lib_clk_div_monitor.sv
// Divided-clock monitor: synchronizes clkdiv, checks edge spacing against DIV, tracks lock.
// Define CTECH_CLK_DIV_MON_ERRCNT_EN to build the saturating spacing-error counter on err_cnt.
module ctech_lib_clk_div_monitor #(
    parameter int DIV         = 2,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkdiv,
    input  logic       enable,
    input  logic       err_clr,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF      = CW'(DIV / 2);
    localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] RUN_SAT   = CW'(DIV);
    localparam logic [3:0]    LOCK_LAST = 4'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   edge_det;
    logic                   edge_rise;
    logic [CW-1:0]          run_cnt;
    logic [3:0]             good_cnt;
    logic                   good;
    logic                   early;
    logic                   late;
    logic                   err_event;

    // Edge flag is registered once more so the strobe appears SYNC_STAGES+1 cycles after the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            hist      <= 1'b0;
            edge_det  <= 1'b0;
            edge_rise <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], clkdiv};
            hist      <= sync[SYNC_STAGES-1];
            edge_det  <= sync[SYNC_STAGES-1] ^ hist;
            edge_rise <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (edge_det) begin
            run_cnt <= '0;
        end else if (run_cnt != RUN_SAT) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // run_cnt+1 < DIV/2 avoids a constant "< 0" compare when DIV=2.
    always_comb begin
        good      = edge_det && (run_cnt == HALF_M1);
        early     = edge_det && (CW'(run_cnt + 1'b1) < HALF);
        late      = !edge_det && (run_cnt == HALF_M1);
        err_event = enable && (state == LOCKED) && (early || late);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = ACQ;
            ACQ:     if (edge_det) state_next = TRACK;
            TRACK: begin
                if (early || late) begin
                    state_next = ACQ;
                end else if (good && (good_cnt == LOCK_LAST)) begin
                    state_next = LOCKED;
                end
            end
            LOCKED:  if (early || late) state_next = ACQ;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        locked   = (state == LOCKED);
        rise_stb = enable && (state != IDLE) && edge_det && edge_rise;
        fall_stb = enable && (state != IDLE) && edge_det && !edge_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
        end else if (!enable || (state == IDLE) || (state == ACQ)) begin
            good_cnt <= '0;
        end else if (state == TRACK) begin
            if (early || late) begin
                good_cnt <= '0;
            end else if (good) begin
                good_cnt <= good_cnt + 1'b1;
            end
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

`ifdef CTECH_CLK_DIV_MON_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_event) begin
            if (err_clr) begin
                err_cnt_q <= 8'd1;
            end else if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ctech_lib_clk_div_monitor.sv
// Bench for ctech_lib_clk_div_monitor: a DIV=2 and a DIV=4 instance checked against a cycle model.
// Expected err_cnt values follow CTECH_CLK_DIV_MON_ERRCNT_EN.
module tb_ctech_lib_clk_div_monitor;

    localparam int S     = 2;
    localparam int LOCKN = 4;
`ifdef CTECH_CLK_DIV_MON_ERRCNT_EN
    localparam int ERRONE = 1;
`else
    localparam int ERRONE = 0;
`endif

    typedef struct {
        logic       en;
        logic       cd;
        logic       clr;
        logic       rise;
        logic       fall;
        logic       lck;
        logic       er;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en  = '0;
    logic [1:0] cd  = '0;
    logic [1:0] clr = '0;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lck;
    logic [1:0] er;
    logic [7:0] ecnt0;
    logic [7:0] ecnt1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int divs [2] = '{2, 4};

    // Reference model: mode 0 idle, 1 acquiring, 2 tracking, 3 locked.
    int m_mode [2];
    int m_good [2];
    int m_cnt  [2];
    int m_last [2];
    int ph     [2] = '{0, 0};
    bit m_err  [2];
    bit m_smp  [2][8];

    vec_t tbl [17];

    ctech_lib_clk_div_monitor #(.DIV(2), .LOCK_CNT(LOCKN), .SYNC_STAGES(S)) u_dut2 (
        .clk(clk), .rst(rst), .clkdiv(cd[0]), .enable(en[0]), .err_clr(clr[0]),
        .rise_stb(rise[0]), .fall_stb(fall[0]), .locked(lck[0]), .err(er[0]), .err_cnt(ecnt0)
    );

    ctech_lib_clk_div_monitor #(.DIV(4), .LOCK_CNT(LOCKN), .SYNC_STAGES(S)) u_dut4 (
        .clk(clk), .rst(rst), .clkdiv(cd[1]), .enable(en[1]), .err_clr(clr[1]),
        .rise_stb(rise[1]), .fall_stb(fall[1]), .locked(lck[1]), .err(er[1]), .err_cnt(ecnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input int exp);
        n_chk++;
        if (act !== exp[7:0]) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? ecnt0 : ecnt1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0;
            m_good[d] = 0;
            m_cnt[d]  = 0;
            m_err[d]  = 1'b0;
            m_last[d] = -1000;
            for (int j = 0; j < 8; j++) m_smp[d][j] = 1'b0;
        end
    endtask

    // Advance one clock: classify the finished cycle by distance to the previous edge.
    task automatic model_update(input int d);
        bit dp, good, early, late, ev;
        int gap, half;
        half  = divs[d] / 2;
        dp    = m_smp[d][S] != m_smp[d][S+1];
        gap   = cyc - m_last[d];
        good  = dp && (gap == half);
        early = dp && (gap < half);
        late  = !dp && (gap == half);
        ev    = en[d] && (m_mode[d] == 3) && (early || late);
        if (!en[d]) begin
            m_mode[d] = 0;
            m_good[d] = 0;
        end else begin
            case (m_mode[d])
                0: m_mode[d] = 1;
                1: if (dp) begin m_mode[d] = 2; m_good[d] = 0; end
                2: begin
                    if (early || late) begin
                        m_mode[d] = 1;
                        m_good[d] = 0;
                    end else if (good) begin
                        m_good[d]++;
                        if (m_good[d] == LOCKN) m_mode[d] = 3;
                    end
                end
                default: if (early || late) m_mode[d] = 1;
            endcase
        end
        if (ev) m_err[d] = 1'b1;
        else if (clr[d]) m_err[d] = 1'b0;
`ifdef CTECH_CLK_DIV_MON_ERRCNT_EN
        if (ev) m_cnt[d] = clr[d] ? 1 : ((m_cnt[d] < 255) ? m_cnt[d] + 1 : 255);
        else if (clr[d]) m_cnt[d] = 0;
`endif
        if (dp) m_last[d] = cyc;
        for (int j = 7; j > 0; j--) m_smp[d][j] = m_smp[d][j-1];
        m_smp[d][0] = cd[d];
    endtask

    // Called at posedge+1 with inputs already driven; compares, then advances one clock.
    task automatic step();
        bit det, act;
        #1;
        for (int d = 0; d < 2; d++) begin
            det = m_smp[d][S] != m_smp[d][S+1];
            act = en[d] && (m_mode[d] != 0) && det;
            chk($sformatf("rise_stb[%0d]", d), rise[d], int'(act && m_smp[d][S]));
            chk($sformatf("fall_stb[%0d]", d), fall[d], int'(act && !m_smp[d][S]));
            chk($sformatf("locked[%0d]", d), lck[d], int'(m_mode[d] == 3));
            chk($sformatf("err[%0d]", d), er[d], int'(m_err[d]));
            chk($sformatf("err_cnt[%0d]", d), cnt_of(d), m_cnt[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d);
        cyc++;
        #1;
    endtask

    task automatic regular_inputs();
        for (int d = 0; d < 2; d++) begin
            en[d]  = 1'b1;
            clr[d] = 1'b0;
            ph[d]++;
            if (ph[d] >= divs[d] / 2) begin
                cd[d] = ~cd[d];
                ph[d] = 0;
            end
        end
    endtask

    task automatic wait_lock(input int d, input string name);
        int k;
        k = 0;
        while (m_mode[d] != 3 && k < 200) begin
            regular_inputs();
            step();
            k++;
        end
        chk(name, lck[d], 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rise[%0d]", d), rise[d], 0);
            chk($sformatf("rst_fall[%0d]", d), fall[d], 0);
            chk($sformatf("rst_locked[%0d]", d), lck[d], 0);
            chk($sformatf("rst_err[%0d]", d), er[d], 0);
            chk($sformatf("rst_err_cnt[%0d]", d), cnt_of(d), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic hold;
        bit   tog;
        int   k;

        // DIV=2 acquisition, lock, then clkdiv stuck high (hand-derived).
        for (int i = 0; i < 17; i++) begin
            tbl[i].en   = 1'b1;
            tbl[i].cd   = (i <= 10) ? logic'(i % 2) : 1'b1;
            tbl[i].clr  = 1'b0;
            tbl[i].rise = (i >= 4) && (i <= 14) && (i % 2 == 0);
            tbl[i].fall = (i >= 5) && (i <= 13) && (i % 2 == 1);
            tbl[i].lck  = (i >= 9) && (i <= 15);
            tbl[i].er   = (i == 16);
            tbl[i].cnt  = (i == 16) ? 8'(ERRONE) : 8'd0;
        end

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        cyc = 0;

        for (int i = 0; i < 17; i++) begin
            regular_inputs();
            en[0]  = tbl[i].en;
            cd[0]  = tbl[i].cd;
            clr[0] = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_rise", i), rise[0], int'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i), fall[0], int'(tbl[i].fall));
            chk($sformatf("tbl%0d_locked", i), lck[0], int'(tbl[i].lck));
            chk($sformatf("tbl%0d_err", i), er[0], int'(tbl[i].er));
            chk($sformatf("tbl%0d_err_cnt", i), ecnt0, int'(tbl[i].cnt));
            step();
        end

        // DIV=4: one extra toggle a cycle after a regular edge.
        wait_lock(1, "lock_div4");
        k = 0;
        do begin
            regular_inputs();
            tog = (ph[1] == 0);
            step();
            k++;
        end while (!tog && k < 10);
        regular_inputs();
        cd[1] = ~cd[1];
        ph[1] = 0;
        step();
        repeat (4) begin regular_inputs(); step(); end
        chk("early_err", er[1], 1);
        chk("early_unlock", lck[1], 0);
        chk("early_err_cnt", ecnt1, ERRONE);
        wait_lock(1, "relock_div4");
        chk("err_sticky", er[1], 1);

        // DIV=2: clear coinciding with a late event, then clear alone.
        regular_inputs();
        clr[0] = 1'b1;
        step();
        wait_lock(0, "relock_div2");
        regular_inputs();
        step();
        hold = cd[0];
        repeat (3) begin regular_inputs(); cd[0] = hold; step(); end
        regular_inputs(); cd[0] = hold; clr[0] = 1'b1; step();
        regular_inputs(); cd[0] = hold; clr[0] = 1'b1;
        #1;
        chk("clr_vs_err", er[0], 1);
        chk("clr_vs_err_cnt", ecnt0, ERRONE);
        step();
        regular_inputs(); cd[0] = hold;
        #1;
        chk("clr_alone", er[0], 0);
        chk("clr_alone_cnt", ecnt0, 0);
        step();

        // Reset pulse while both are locked.
        wait_lock(0, "lock_pre_rst0");
        wait_lock(1, "lock_pre_rst1");
        do_reset();
        wait_lock(0, "relock_rst0");
        wait_lock(1, "relock_rst1");
        chk("post_rst_err0", er[0], 0);
        chk("post_rst_err1", er[1], 0);

        // One-cycle enable drop while locked.
        regular_inputs();
        en[0] = 1'b0;
        #1;
        chk("en_drop_strobe", rise[0] | fall[0], 0);
        step();
        regular_inputs();
        #1;
        chk("en_drop_unlock", lck[0], 0);
        chk("en_drop_err", er[0], 0);
        step();
        wait_lock(0, "relock_en");

        // Randomized traffic: glitches, missing edges, enable drops, clears, resets.
        for (int i = 0; i < 3000; i++) begin
            regular_inputs();
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 49) == 0) cd[d] = ~cd[d];
                en[d]  = ($urandom_range(0, 79) != 0);
                clr[d] = ($urandom_range(0, 24) == 0);
            end
            if ($urandom_range(0, 699) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctech_lib_clk_div_monitor.md
CTECH_LIB_CLK_DIV_MONITOR -- requirements
Module: ctech_lib_clk_div_monitor

Interface
REQ-001 Parameter DIV, default 2: expected division ratio of the observed clock; even only, legal range 2..16.
REQ-002 Parameter LOCK_CNT, default 4: consecutive correctly spaced edges needed to declare lock; legal range 1..15.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on clkdiv; legal range 2..3.
REQ-004 clk  in  1  source clock from which clkdiv is derived; single clock domain.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 clkdiv  in  1  divided clock under observation, treated as asynchronous data.
REQ-007 enable  in  1  monitor enable; low forces IDLE.
REQ-008 err_clr  in  1  single-cycle clear of the sticky error.
REQ-009 rise_stb  out  1  one-cycle pulse per detected clkdiv rising edge.
REQ-010 fall_stb  out  1  one-cycle pulse per detected clkdiv falling edge.
REQ-011 locked  out  1  high while in LOCKED.
REQ-012 err  out  1  sticky spacing-error flag.
REQ-013 err_cnt  out  8  saturating error count (see Configuration).

Function
REQ-014 clkdiv SHALL pass through SYNC_STAGES flops, then one history flop; edge = synced XOR history.
REQ-015 Latency from a clkdiv transition (sampled at a clk edge) to the rise_stb/fall_stb pulse SHALL be SYNC_STAGES+1 cycles.
REQ-016 Strobes SHALL pulse in every state except IDLE; in IDLE they SHALL stay 0.
REQ-017 run_cnt, width $clog2(DIV)+1, SHALL clear to 0 on a detected edge, otherwise increment, saturating at DIV.
REQ-018 A good edge SHALL be an edge detected while run_cnt == DIV/2-1.
REQ-019 An early event SHALL be an edge detected while run_cnt < DIV/2-1.
REQ-020 A late event SHALL be a cycle with no edge while run_cnt == DIV/2-1.
REQ-021 FSM states SHALL be IDLE, ACQ, TRACK and LOCKED.
REQ-022 IDLE -> ACQ when enable=1.
REQ-023 Any state -> IDLE when enable=0; this SHALL take priority over all other transitions.
REQ-024 ACQ -> TRACK on the first detected edge; good_cnt cleared; no spacing check in ACQ.
REQ-025 In TRACK, each good edge SHALL increment good_cnt; when good_cnt reaches LOCK_CNT the FSM SHALL enter LOCKED on the next cycle.
REQ-026 TRACK on an early or late event -> ACQ, good_cnt cleared; err SHALL NOT be set.
REQ-027 LOCKED on an early or late event -> ACQ; err set; locked deasserts in the same cycle the FSM leaves LOCKED.
REQ-028 err_clr SHALL clear err; a new error in the same cycle SHALL win, leaving err=1.
REQ-029 Early or late events SHALL be ignored in IDLE and ACQ.

Reset
REQ-030 While rst=1, synchronizer, history, run_cnt, good_cnt, err and err_cnt SHALL be 0, and the FSM SHALL be in IDLE.
REQ-031 While rst=1, all outputs SHALL be 0.
REQ-032 Reset asserted mid-lock SHALL drop locked asynchronously.
REQ-033 After rst falls, detection SHALL restart from ACQ once enable=1; no error SHALL be flagged for the partial period around reset.

Configuration
REQ-034 With CTECH_CLK_DIV_MON_ERRCNT_EN defined, err_cnt SHALL increment by one on each event that sets err.
REQ-035 With CTECH_CLK_DIV_MON_ERRCNT_EN defined, err_cnt SHALL saturate at 255 and be cleared by err_clr; a simultaneous error SHALL yield err_cnt=1.
REQ-036 Without CTECH_CLK_DIV_MON_ERRCNT_EN, err_cnt SHALL be tied to 8'h00 and the counter SHALL NOT exist.

Verification
REQ-037 DIV=2, LOCK_CNT=4, SYNC_STAGES=2: enable=1, clkdiv toggling every clk -> strobes alternate each cycle starting 3 cycles after the first toggle; locked=1 one cycle after the 4th good edge that follows the ACQ edge; err=0.
REQ-038 Locked, then clkdiv held at 1 -> in the first edgeless cycle, late event, locked=0, err=1, state=ACQ; err_cnt=1 with the macro, 0 without.
REQ-039 DIV=4, locked, then one extra clkdiv toggle one cycle after an edge -> early event, err=1; after 4 further good edges, locked=1 again and err remains 1.
REQ-040 err_clr pulsed in the same cycle as a LOCKED late event -> err=1, err_cnt=1; err_clr alone one cycle later -> err=0, err_cnt=0.
REQ-041 rst pulsed for 1 cycle while locked -> locked=0 immediately and all outputs 0; after release, relock after 1+LOCK_CNT edges with err=0.
REQ-042 enable dropped for 1 cycle while locked -> no strobes that cycle, state IDLE, err unchanged; relock follows the normal ACQ/TRACK sequence.
